mdu_pipe: RTL
=============

Name: mdu_pipe

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the 5-stage pipeline.
- Lives in the E stage and replaces the fixed-latency MD unit.
- Drives the busy signal that the hazard unit uses to stall MD instructions in D.
- Adds configurable width and latencies, unsigned/signed variants, defined divide-by-zero/overflow results, a done pulse and cancel (flush) support.

Parameters:
WIDTH, 32, operand/HI/LO width in bits (>=8)
MULT_CYCLES, 5, cycles busy after a multiply is accepted (>=1)
DIV_CYCLES, 10, cycles busy after a divide is accepted (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  request to issue op this cycle
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
a  input  WIDTH  rs operand (forwarded value)
b  input  WIDTH  rt operand (forwarded value)
cancel  input  1  abort in-flight op (pipeline flush)
busy  output  1  op in flight; MD instructions must stall in D
done  output  1  one-cycle pulse on the cycle HI/LO take a result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (clk edge with reset=1): hi=0, lo=0, cycle counter=0, busy=0, done=0. Any in-flight op is discarded. Reset overrides start and cancel.
- Accept: the op is accepted at an edge where start=1, busy=0 and cancel=0. Otherwise start is ignored; the upstream stall keeps it held.
- Operand capture: a, b and op are captured at the accept edge. Later changes on a/b have no effect.
- MULT/MULTU/DIV/DIVU latency:
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES; busy = (counter != 0), so busy is high for exactly LAT cycles after the accept edge.
  - On the edge where the counter goes 1->0, hi/lo load the result and done=1 for that following cycle only.
  - hi/lo hold their old values while busy.
- MULT: {hi,lo} = signed a * signed b, 2*WIDTH bits. MULTU: same, unsigned.
- DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Divisor 0: lo = all ones, hi = a.
  - MIN / -1 (a=100..0, b=all ones): lo = a, hi = 0.
- DIVU: unsigned. Divisor 0: lo = all ones, hi = a.
- MTHI/MTLO:
  - Take effect at the accept edge (hi=a or lo=a).
  - busy stays 0 and there is no done pulse.
  - They are not accepted while busy.
- Cancel:
  - If cancel=1 while busy, the counter clears at that edge and busy=0 the next cycle.
  - hi/lo keep their pre-op values and there is no done pulse.
  - If cancel=1 on the completion edge (counter==1), cancel wins and no writeback occurs.
  - cancel=1 while idle has no effect and blocks any simultaneous start.
- Back-to-back: a new op may be accepted on the cycle done=1, because busy is already 0.
- MFHI/MFLO are not ops here. The pipeline reads hi/lo directly and must stall while busy=1.
- Op codes 6/7 follow Optional Feature.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 6 MADD: {hi,lo} = {hi,lo} + signed a*b, mod 2^(2*WIDTH).
  - op 7 MSUB: {hi,lo} = {hi,lo} - signed a*b, mod 2^(2*WIDTH).
  - Both use MULT_CYCLES, the {hi,lo} value captured at the accept edge, and the same done/cancel rules.
- Undefined: op 6/7 with start=1 is ignored. busy stays 0 and hi/lo are unchanged.

Test Plan:
- Reset, then MULT a=-3 (0xFFFFFFFD), b=7 -> busy high for exactly 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 -> hi updated at the next edge with no busy. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1. Then a start held while busy is accepted only on the done cycle.
- After MTLO a=5, start DIV and assert cancel in the 4th busy cycle -> busy=0 next cycle, no done, lo=5. Also assert reset mid-MULT -> hi=lo=0, busy=0.
- With MDU_MADD_EN and hi=0, lo=10: MADD a=3, b=4 -> lo=22. Then MSUB a=5, b=5 -> {hi,lo}=-3 (0xFFFFFFFF, 0xFFFFFFFD). Without the macro, the same stimuli leave hi/lo unchanged and busy=0.

Source files
------------

// File: rtl/mdu_pipe.sv
// Multiply/divide unit with HI/LO for the E stage; counter-timed latency, cancel on flush.
// Optional MADD/MSUB accumulate ops are enabled with `define MDU_MADD_EN.
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXLAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MAXLAT + 1);
  localparam logic [CW-1:0] MLAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DLAT = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  logic [CW-1:0]      cnt;
  req_t               req;
  logic               accept;
  logic               is_long;
  logic [CW-1:0]      lat;
  logic [2*WIDTH-1:0] res;
  logic signed [2*WIDTH-1:0] sa, sb, sprod;
  logic [2*WIDTH-1:0] ua, ub, uprod;
  logic [WIDTH-1:0]   q, r;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
`endif

  assign busy   = (cnt != '0);
  assign accept = start & ~busy & ~cancel;

  // Which ops occupy the unit, and for how long
  always_comb begin
    is_long = 1'b0;
    lat     = MLAT;
    case (op_e'(op))
      OP_MULT, OP_MULTU: begin is_long = 1'b1; lat = MLAT; end
      OP_DIV,  OP_DIVU:  begin is_long = 1'b1; lat = DLAT; end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:  begin is_long = 1'b1; lat = MLAT; end
`endif
      default: ;
    endcase
  end

  // Result is formed from the captured request; only sampled at the completion edge
  assign sa    = {{WIDTH{req.a[WIDTH-1]}}, req.a};
  assign sb    = {{WIDTH{req.b[WIDTH-1]}}, req.b};
  assign sprod = sa * sb;
  assign ua    = {{WIDTH{1'b0}}, req.a};
  assign ub    = {{WIDTH{1'b0}}, req.b};
  assign uprod = ua * ub;

  always_comb begin
    q = '1;
    r = req.a;
    if (req.b != '0) begin
      if (req.op == OP_DIVU) begin
        q = req.a / req.b;
        r = req.a % req.b;
      end else if (req.a == MIN_VAL && req.b == '1) begin
        // Signed overflow: quotient wraps to MIN, remainder is zero
        q = req.a;
        r = '0;
      end else begin
        q = WIDTH'($signed(req.a) / $signed(req.b));
        r = WIDTH'($signed(req.a) % $signed(req.b));
      end
    end
  end

  always_comb begin
    res = '0;
    case (req.op)
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_DIV,
      OP_DIVU:  res = {r, q};
`ifdef MDU_MADD_EN
      OP_MADD:  res = acc + sprod;
      OP_MSUB:  res = acc - sprod;
`endif
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      req  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
`ifdef MDU_MADD_EN
      acc  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (cancel) begin
        // Flush beats completion; idle cancel also swallows any start
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          {hi, lo} <= res;
          done     <= 1'b1;
        end
      end else if (accept) begin
        if (op_e'(op) == OP_MTHI) hi <= a;
        if (op_e'(op) == OP_MTLO) lo <= a;
        if (is_long) begin
          req <= '{op: op_e'(op), a: a, b: b};
          cnt <= lat;
`ifdef MDU_MADD_EN
          acc <= {hi, lo};
`endif
        end
      end
    end
  end

endmodule
